// File: rtl/memc_arbiter_if.sv
// -----------------------------------------------------------------------------
// memc_arbiter_if
//   Request/response bundle for one memc_arbiter client port.
//   master : the requesting client (CPU bus or loader/debug port)
//   slave  : the arbiter side
//   Signals:
//     req      level request, held until done
//     wr       1 = write, 0 = read; sampled with the grant
//     addr     transaction address; sampled with the grant
//     wr_data  write data; sampled with the grant
//     gnt      one-cycle pulse, request accepted
//     done     one-cycle pulse, transaction complete
//     rd_data  last read data returned to this port, held between reads
// -----------------------------------------------------------------------------
interface memc_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
);
    logic                  req;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  gnt;
    logic                  done;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output req, wr, addr, wr_data,
        input  gnt, done, rd_data
    );

    modport slave (
        input  req, wr, addr, wr_data,
        output gnt, done, rd_data
    );
endinterface

// File: rtl/memc_arbiter.sv
// -----------------------------------------------------------------------------
// memc_arbiter
//   Two-port round-robin arbiter and sequencer in front of memc. Port 0 is the
//   CPU bus, port 1 the loader/debug port. Single-byte reads/writes are issued
//   one at a time as a one-cycle enable strobe, the fixed memc latency is
//   waited out, then read data and a done pulse go back to the winning port.
//   Ports:
//     arb_clk         clock, rising edge
//     arb_reset       asynchronous active-low reset
//     p0, p1          client ports (memc_arbiter_if.slave)
//     memc_busy       memc not ready; blocks new grants (sampled in IDLE only)
//     memc_rd_enable  one-cycle read strobe
//     memc_wr_enable  one-cycle write strobe
//     memc_addr       latched transaction address
//     memc_wr_data    latched write data
//     memc_rd_data    read data from memc
// -----------------------------------------------------------------------------
module memc_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int RD_LAT     = 3,
    parameter int WR_LAT     = 2
) (
    input  logic                  arb_clk,
    input  logic                  arb_reset,
    memc_arbiter_if.slave         p0,
    memc_arbiter_if.slave         p1,
    input  logic                  memc_busy,
    output logic                  memc_rd_enable,
    output logic                  memc_wr_enable,
    output logic [ADDR_WIDTH-1:0] memc_addr,
    output logic [DATA_WIDTH-1:0] memc_wr_data,
    input  logic [DATA_WIDTH-1:0] memc_rd_data
);

    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  win_q;
    logic                  last_q;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] rd0_q;
    logic [DATA_WIDTH-1:0] rd1_q;

    logic                  grant;
    logic                  sel;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Arbitration: a lone requester wins; on a tie the port that did not win
    // last time goes first, which makes two held requests alternate.
    always_comb begin
        grant     = (state_q == IDLE) && !memc_busy && (p0.req || p1.req);
        sel       = (p0.req && p1.req) ? ~last_q : p1.req;
        sel_wr    = sel ? p1.wr      : p0.wr;
        sel_addr  = sel ? p1.addr    : p0.addr;
        sel_wdata = sel ? p1.wr_data : p0.wr_data;
    end

    // State register
    always_ff @(posedge arb_clk or negedge arb_reset) begin
        if (!arb_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Transaction latches, latency counter and per-port read data
    always_ff @(posedge arb_clk or negedge arb_reset) begin
        if (!arb_reset) begin
            win_q   <= 1'b0;
            last_q  <= 1'b1;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            if (grant) begin
                win_q  <= sel;
                wr_q   <= sel_wr;
                addr_q <= sel_addr;
                if (sel_wr) begin
                    wdata_q <= sel_wdata;
                end
            end

            // The counter runs from LAT down to 0 inclusive, so WAIT spans
            // LAT+1 cycles and done lands LAT+2 edges after the grant edge.
            if (state_q == ISSUE) begin
                cnt_q <= wr_q ? CNT_W'(WR_LAT) : CNT_W'(RD_LAT);
            end else if (state_q == WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end

            // Read data is captured on the edge that enters DONE.
            if (state_q == WAIT && cnt_q == '0 && !wr_q) begin
                if (win_q) begin
                    rd1_q <= memc_rd_data;
                end else begin
                    rd0_q <= memc_rd_data;
                end
            end

            if (state_q == DONE) begin
                last_q <= win_q;
            end
        end
    end

    // Output decode
    always_comb begin
        p0.gnt         = (state_q == ISSUE) && !win_q;
        p1.gnt         = (state_q == ISSUE) &&  win_q;
        p0.done        = (state_q == DONE)  && !win_q;
        p1.done        = (state_q == DONE)  &&  win_q;
        memc_rd_enable = (state_q == ISSUE) && !wr_q;
        memc_wr_enable = (state_q == ISSUE) &&  wr_q;
    end

    assign memc_addr    = addr_q;
    assign memc_wr_data = wdata_q;
    assign p0.rd_data   = rd0_q;
    assign p1.rd_data   = rd1_q;

endmodule
